uart_core: RTL
==============

# uart_core

Byte-level 8N1 UART transceiver. It sits directly downstream of the memory-mapped UART address decoder and serves the CPU's UART address window.
- Transmit side: accepts a byte on a valid/ready handshake and serializes it onto `SOut`.
- Receive side: deserializes `SIn`, then holds the byte on `DataOut` until the decoder acknowledges it with `DataOutReady`.

## Interface
- `ClockFreq`, 100_000_000, system clock frequency in Hz.
- `BaudRate`, 115_200, line rate in bits per second.
- Derived constant `T = ClockFreq / BaudRate`, integer division (868 at the defaults). Counter width is `clog2(T)`. `T` must be ≥ 4.

Ports:
- `Clock`  in  1  system clock; all logic is on the rising edge.
- `Reset_n`  in  1  synchronous reset, active-low.
- `DataIn`  in  8  byte to transmit.
- `DataInValid`  in  1  `DataIn` is valid.
- `DataInReady`  out  1  transmitter is idle and can accept a byte.
- `DataOut`  out  8  last received byte.
- `DataOutValid`  out  1  `DataOut` holds an unread byte.
- `DataOutReady`  in  1  consumer takes `DataOut`.
- `SIn`  in  1  serial input; asynchronous to `Clock`.
- `SOut`  out  1  serial output.
- `FramingError`  out  1  one-cycle pulse when a frame's stop bit samples 0.
- `Overrun`  out  1  one-cycle pulse when a received byte overwrites an unread byte.

## Operation
- Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts exactly `T` cycles. There is no parity bit.
- All outputs are registered.
- Values while `Reset_n` is low at an edge:
  - `SOut` = 1, `DataInReady` = 1
  - `DataOut` = 0x00, `DataOutValid` = 0
  - `FramingError` = 0, `Overrun` = 0
  - both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame immediately. No partial byte is delivered.

TX FSM: IDLE → START → DATA(0..7) → STOP → IDLE.
- IDLE: `DataInReady` = 1, `SOut` = 1.
- Acceptance is `DataInValid & DataInReady` at an edge. At that edge the block latches `DataIn` into the shift register, drives `DataInReady` to 0, and enters START.
- `DataIn` is ignored while `DataInReady` = 0. `DataInValid` held high while busy does not queue a second byte.
- Each state holds for `T` cycles under a bit counter, then advances.
- STOP drives `SOut` = 1. Leaving STOP sets `DataInReady` = 1.

RX FSM: IDLE → START → DATA(0..7) → STOP → IDLE.
- `SIn` passes through a 2-flop synchronizer, giving `sin_s`. All RX logic uses `sin_s`.
- IDLE → START when `sin_s` = 0.
- Sampling points, counted from detection:
  - At `T/2` cycles (integer), the start bit is checked. If `sin_s` = 1 it was a glitch: return to IDLE with no output.
  - Data bit `i` is sampled at `T/2 + (i+1)·T`.
  - The stop bit is sampled at `T/2 + 9·T`.
- Stop bit = 1:
  - Load `DataOut` and set `DataOutValid` = 1.
  - If `DataOutValid` was already 1 and `DataOutReady` is 0 at that edge, the new byte overwrites and `Overrun` pulses.
- Stop bit = 0: the byte is discarded. `FramingError` pulses and `DataOut`/`DataOutValid` are unchanged.
- After the stop sample the FSM returns to IDLE and needs `sin_s` = 1 before a new start is detected.
- `DataOutValid` clears at the first edge where `DataOutReady` = 1.
  - A high `DataOutReady` held for several cycles, as the decoder does during a load, clears `DataOutValid` once and has no other effect.
- Simultaneous `DataOutReady` and a new byte loading: the new byte loads, `DataOutValid` stays 1, and there is no `Overrun`.

## Timing
- TX, with acceptance at edge `k`:
  - `SOut` = 0 from cycle `k+1` to `k+T`.
  - Bit `i` from `k+1+(i+1)T` to `k+(i+2)T`.
  - Stop bit from `k+1+9T` to `k+10T`.
  - `DataInReady` = 1 from `k+1+10T`. A new acceptance is possible at that edge, so back-to-back frames have no idle gap.
- RX:
  - 2-cycle synchronizer latency.
  - With `d` as the first cycle where `sin_s` = 0, `DataOutValid` rises at edge `d + T/2 + 9T + 1`.
  - `FramingError`/`Overrun` pulse in that same cycle for exactly one cycle.
- TX and RX are fully independent. A simultaneous loopback of `SOut` to `SIn` must work.

## Test plan
Benches use `ClockFreq` = 1000 and `BaudRate` = 100, so `T` = 10.
- Reset: hold `Reset_n` = 0 for 3 cycles with `DataInValid` = 1 → `SOut` = 1, `DataInReady` = 1, `DataOutValid` = 0. No transmission starts until after release.
- TX 0x55, accepted at edge `k`:
  - `SOut` reads 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles, starting at `k+1`.
  - `DataInReady` = 0 for cycles `k+1`..`k+100` and returns to 1 at `k+101`.
  - A second valid byte presented at `k+50` is ignored.
- Loopback `SOut`→`SIn`, sending 0xA3 then 0x0F back-to-back:
  - `DataOut` = 0xA3 with `DataOutValid` = 1, acknowledged by `DataOutReady`.
  - Then `DataOut` = 0x0F.
  - `FramingError` = 0 and `Overrun` = 0 throughout.
- RX glitch and framing:
  - 3-cycle low pulse on `SIn` → no `DataOutValid` and no pulse.
  - Frame 0x81 with the stop bit held 0 → `FramingError` pulses once, `DataOutValid` stays 0.
- Overrun: receive 0x11 and 0x22 without asserting `DataOutReady` → `Overrun` pulses once, then `DataOut` = 0x22 and `DataOutValid` = 1. Holding `DataOutReady` = 1 for 5 cycles → `DataOutValid` = 0 after the first edge.
- Reset mid-frame: deassert `Reset_n` during TX bit 4 and during RX bit 4 → at the next edge `SOut` = 1 and `DataInReady` = 1. No `DataOutValid` from the aborted RX frame.

Source files
------------

// File: rtl/uart_core.sv
// 8N1 UART transceiver with independent TX and RX state machines.
// Byte handshakes on the parallel side; the RX line is synchronized before any use.
//
// state | meaning
// IDLE  | TX: ready for a byte, line high.  RX: waiting for a falling edge on sin_s
// START | TX: driving the start bit.       RX: waiting for the mid-start-bit check
// DATA  | TX: shifting data bits LSB first. RX: sampling data bits mid-bit
// STOP  | TX: driving the stop bit.        RX: waiting for the mid-stop-bit sample
module uart_core #(
   parameter int ClockFreq = 100_000_000,
   parameter int BaudRate  = 115_200
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic [7:0] DataIn,
   input  logic       DataInValid,
   output logic       DataInReady,
   output logic [7:0] DataOut,
   output logic       DataOutValid,
   input  logic       DataOutReady,
   input  logic       SIn,
   output logic       SOut,
   output logic       FramingError,
   output logic       Overrun
);

   localparam int T  = ClockFreq / BaudRate;
   localparam int CW = $clog2(T);
   localparam logic [CW-1:0] BIT_LAST  = CW'(T - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(T / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;

   state_t        rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          sin_meta;
   logic          sin_s;
   logic          sin_prev;

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         tx_state    <= IDLE;
         tx_cnt      <= '0;
         tx_bit      <= '0;
         tx_shift    <= '0;
         SOut        <= 1'b1;
         DataInReady <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               SOut        <= 1'b1;
               DataInReady <= 1'b1;
               if (DataInValid && DataInReady) begin
                  tx_shift    <= DataIn;
                  SOut        <= 1'b0;
                  DataInReady <= 1'b0;
                  tx_cnt      <= BIT_LAST;
                  tx_state    <= START;
               end
            end
            START: begin
               if (tx_cnt == '0) begin
                  tx_cnt   <= BIT_LAST;
                  tx_bit   <= '0;
                  SOut     <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            DATA: begin
               if (tx_cnt == '0) begin
                  tx_cnt <= BIT_LAST;
                  if (tx_bit == 3'd7) begin
                     SOut     <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     SOut     <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            STOP: begin
               if (tx_cnt == '0) begin
                  tx_state    <= IDLE;
                  DataInReady <= 1'b1;
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   // sin_prev makes start detection edge-based, so a line stuck low after a
   // bad stop bit cannot immediately retrigger a frame.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         sin_meta     <= 1'b1;
         sin_s        <= 1'b1;
         sin_prev     <= 1'b1;
         rx_state     <= IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         DataOut      <= 8'h00;
         DataOutValid <= 1'b0;
         FramingError <= 1'b0;
         Overrun      <= 1'b0;
      end else begin
         sin_meta     <= SIn;
         sin_s        <= sin_meta;
         sin_prev     <= sin_s;
         FramingError <= 1'b0;
         Overrun      <= 1'b0;
         if (DataOutReady) begin
            DataOutValid <= 1'b0;
         end
         case (rx_state)
            IDLE: begin
               if (!sin_s && sin_prev) begin
                  rx_cnt   <= HALF_LAST;
                  rx_state <= START;
               end
            end
            START: begin
               if (rx_cnt == '0) begin
                  if (sin_s) begin
                     rx_state <= IDLE;
                  end else begin
                     rx_cnt   <= BIT_LAST;
                     rx_bit   <= '0;
                     rx_state <= DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            DATA: begin
               if (rx_cnt == '0) begin
                  rx_shift <= {sin_s, rx_shift[7:1]};
                  rx_cnt   <= BIT_LAST;
                  if (rx_bit == 3'd7) begin
                     rx_state <= STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            STOP: begin
               if (rx_cnt == '0) begin
                  rx_state <= IDLE;
                  if (sin_s) begin
                     DataOut      <= rx_shift;
                     DataOutValid <= 1'b1;
                     Overrun      <= DataOutValid && !DataOutReady;
                  end else begin
                     FramingError <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

endmodule
